// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a serial-in/parallel-out shift register with bit and word handshakes.
// Optional even-parity check is enabled by defining SIPO_PARITY_CHECK_EN.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             sin_ready,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             busy,
    output logic             frame_drop,
    output logic             par_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
`ifdef SIPO_PARITY_CHECK_EN
        PARITY = 2'd2,
`endif
        HOLD   = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;

    assign pout = sr;

`ifdef SIPO_PARITY_CHECK_EN
    logic par_err_q;
    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // Sequencer: state, datapath and all handshake outputs update together.
    always_ff @(posedge clk) begin
        if (r) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            sin_ready  <= 1'b0;
            pout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_drop <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            frame_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sr        <= '0;
                        cnt       <= '0;
                        state     <= SHIFT;
                        sin_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        frame_drop <= 1'b1;
                    end
                    if (sin_valid) begin
                        sr  <= {sr[WIDTH-2:0], sin};
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_CHECK_EN
                            state      <= PARITY;
`else
                            state      <= HOLD;
                            sin_ready  <= 1'b0;
                            pout_valid <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SIPO_PARITY_CHECK_EN
                PARITY: begin
                    if (start) begin
                        frame_drop <= 1'b1;
                    end
                    // Parity bit is checked against the word but never shifted in.
                    if (sin_valid) begin
                        par_err_q  <= ^{sr, sin};
                        state      <= HOLD;
                        sin_ready  <= 1'b0;
                        pout_valid <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    if (pout_ready) begin
                        pout_valid <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
                        par_err_q  <= 1'b0;
`endif
                        if (start) begin
                            sr        <= '0;
                            cnt       <= '0;
                            state     <= SHIFT;
                            sin_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        frame_drop <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    sin_ready  <= 1'b0;
                    pout_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: directed scenarios plus randomized frames
// checked against a word/parity model; honours SIPO_PARITY_CHECK_EN when defined.
module tb_sipo_frame_ctrl;

    localparam int unsigned WIDTH = 4;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LIMIT = 400;

    logic             clk = 1'b0;
    logic             r = 1'b1;
    logic             start = 1'b0;
    logic             sin = 1'b0;
    logic             sin_valid = 1'b0;
    logic             sin_ready;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready = 1'b0;
    logic             busy;
    logic             frame_drop;
    logic             par_err;

    int checks = 0;
    int errors = 0;

    sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .r          (r),
        .start      (start),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sin_ready  (sin_ready),
        .pout       (pout),
        .pout_valid (pout_valid),
        .pout_ready (pout_ready),
        .busy       (busy),
        .frame_drop (frame_drop),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected par_err: odd total ones over data word plus parity bit.
    function automatic logic exp_parity(input logic [WIDTH-1:0] word, input logic pbit);
        int ones;
        ones = $countones(word) + int'(pbit);
        return (PAR == 1) ? logic'(ones % 2) : 1'b0;
    endfunction

    // Feeds WIDTH data bits MSB-first (plus parity bit if enabled) then waits for pout_valid.
    // gap_mode: 0 = sin_valid every cycle, 1 = alternate cycles, 2 = random.
    task automatic feed(input logic [WIDTH-1:0] word, input logic pbit, input int gap_mode,
                        inout int steps);
        int  i = 0;
        int  budget = 0;
        bit  ready_ok = 1'b1;
        bit  v;
        bit  acc;
        while (i < int'(WIDTH) + PAR && budget < LIMIT) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 1;
                default: v = $urandom_range(0, 2) != 0;
            endcase
            sin_valid = v;
            sin = (i < int'(WIDTH)) ? word[WIDTH-1-i] : pbit;
            if (sin_ready !== 1'b1) ready_ok = 1'b0;
            acc = v && (sin_ready === 1'b1);
            step();
            steps++;
            budget++;
            if (acc) i++;
        end
        sin_valid = 1'b0;
        sin = 1'b0;
        while (pout_valid !== 1'b1 && budget < LIMIT) begin
            step();
            steps++;
            budget++;
        end
        checks++;
        if (budget >= LIMIT) begin
            errors++;
            $display("FAIL frame_timeout got %0d bits after %0d cycles exp %0d bits", i, budget,
                     int'(WIDTH) + PAR);
        end
        checks++;
        if (!ready_ok) begin
            errors++;
            $display("FAIL sin_ready_in_shift got 0 exp 1");
        end
    endtask

    task automatic run_frame(input logic [WIDTH-1:0] word, input logic pbit, input int gap_mode,
                             output int steps);
        steps = 0;
        start = 1'b1;
        step();
        steps++;
        start = 1'b0;
        checks++;
        if (sin_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_to_shift got sin_ready=%b busy=%b exp 1 1", sin_ready, busy);
        end
        feed(word, pbit, gap_mode, steps);
    endtask

    task automatic handshake();
        pout_ready = 1'b1;
        step();
        pout_ready = 1'b0;
        checks++;
        if ({pout_valid, busy, par_err, sin_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL handshake_idle got valid=%b busy=%b par_err=%b ready=%b exp 0 0 0 0",
                     pout_valid, busy, par_err, sin_ready);
        end
    endtask

    task automatic test_reset();
        r = 1'b1;
        step();
        step();
        r = 1'b0;
        checks++;
        if ({sin_ready, pout_valid, busy, frame_drop, par_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {sin_ready, pout_valid, busy, frame_drop, par_err});
        end
        checks++;
        if (pout !== '0) begin
            errors++;
            $display("FAIL reset_pout got %b exp 0", pout);
        end
    endtask

    task automatic test_basic();
        int steps;
        logic [WIDTH-1:0] w = 4'b1011;
        run_frame(w, 1'b1, 0, steps);
        checks++;
        if (steps != int'(WIDTH) + 1 + PAR) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d", steps, int'(WIDTH) + 1 + PAR);
        end
        checks++;
        if (pout !== w || pout_valid !== 1'b1 || busy !== 1'b1 || sin_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold got pout=%b v=%b busy=%b rdy=%b exp %b 1 1 0",
                     pout, pout_valid, busy, sin_ready, w);
        end
        checks++;
        if (par_err !== exp_parity(w, 1'b1)) begin
            errors++;
            $display("FAIL basic_par_err got %b exp %b", par_err, exp_parity(w, 1'b1));
        end
        handshake();
    endtask

    task automatic test_stall();
        int steps;
        bit stable = 1'b1;
        logic [WIDTH-1:0] w = 4'b1011;
        logic exp_pe;
        exp_pe = exp_parity(w, 1'b0);
        run_frame(w, 1'b0, 1, steps);
        checks++;
        if (pout !== w) begin
            errors++;
            $display("FAIL stall_pout got %b exp %b", pout, w);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (pout !== w || pout_valid !== 1'b1 || par_err !== exp_pe) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL hold_stable got pout=%b v=%b pe=%b exp %b 1 %b",
                     pout, pout_valid, par_err, w, exp_pe);
        end
        checks++;
        if (par_err !== exp_pe) begin
            errors++;
            $display("FAIL stall_par_err got %b exp %b", par_err, exp_pe);
        end
        handshake();
    endtask

    task automatic test_drop_b2b();
        int steps;
        logic [WIDTH-1:0] w1 = WIDTH'($urandom);
        logic [WIDTH-1:0] w2 = 4'b0110;
        run_frame(w1, 1'b0, 0, steps);
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (frame_drop !== 1'b1 || pout_valid !== 1'b1 || pout !== w1) begin
            errors++;
            $display("FAIL hold_drop got drop=%b v=%b pout=%b exp 1 1 %b",
                     frame_drop, pout_valid, pout, w1);
        end
        step();
        checks++;
        if (frame_drop !== 1'b0 || pout_valid !== 1'b1) begin
            errors++;
            $display("FAIL drop_pulse got drop=%b v=%b exp 0 1", frame_drop, pout_valid);
        end
        start = 1'b1;
        pout_ready = 1'b1;
        step();
        start = 1'b0;
        pout_ready = 1'b0;
        checks++;
        if ({sin_ready, pout_valid, busy, frame_drop, par_err} !== 5'b10100) begin
            errors++;
            $display("FAIL b2b_shift got %b exp 10100",
                     {sin_ready, pout_valid, busy, frame_drop, par_err});
        end
        steps = 0;
        feed(w2, 1'b0, 0, steps);
        checks++;
        if (pout !== w2 || steps != int'(WIDTH) + PAR) begin
            errors++;
            $display("FAIL b2b_pout got %b in %0d exp %b in %0d", pout, steps, w2,
                     int'(WIDTH) + PAR);
        end
        handshake();
    endtask

    task automatic test_abort();
        int steps;
        logic [WIDTH-1:0] w = 4'b1111;
        start = 1'b1;
        step();
        sin_valid = 1'b1;
        sin = 1'b1;
        step();
        start = 1'b0;
        sin = 1'b0;
        checks++;
        if (frame_drop !== 1'b1 || sin_ready !== 1'b1) begin
            errors++;
            $display("FAIL shift_drop got drop=%b rdy=%b exp 1 1", frame_drop, sin_ready);
        end
        step();
        sin_valid = 1'b0;
        r = 1'b1;
        step();
        r = 1'b0;
        checks++;
        if ({sin_ready, pout_valid, busy, frame_drop, par_err} !== 5'b0 || pout !== '0) begin
            errors++;
            $display("FAIL abort_reset got flags=%b pout=%b exp 00000 0",
                     {sin_ready, pout_valid, busy, frame_drop, par_err}, pout);
        end
        step();
        run_frame(w, 1'b0, 0, steps);
        checks++;
        if (pout !== w || steps != int'(WIDTH) + 1 + PAR) begin
            errors++;
            $display("FAIL abort_refill got %b in %0d exp %b in %0d", pout, steps, w,
                     int'(WIDTH) + 1 + PAR);
        end
        handshake();
    endtask

    task automatic test_random();
        int steps;
        bit in_shift = 1'b0;
        bit b2b;
        logic [WIDTH-1:0] w;
        logic pbit;
        logic exp_pe;
        for (int f = 0; f < 24; f++) begin
            w = WIDTH'($urandom);
            pbit = 1'($urandom);
            exp_pe = exp_parity(w, pbit);
            steps = 0;
            if (in_shift) begin
                feed(w, pbit, 2, steps);
            end else begin
                for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
                run_frame(w, pbit, 2, steps);
            end
            for (int d = 0; d < int'($urandom_range(0, 3)); d++) step();
            checks++;
            if (pout !== w || pout_valid !== 1'b1 || par_err !== exp_pe) begin
                errors++;
                $display("FAIL rand_frame%0d got pout=%b v=%b pe=%b exp %b 1 %b",
                         f, pout, pout_valid, par_err, w, exp_pe);
            end
            b2b = (f != 23) && ($urandom_range(0, 1) == 1);
            start = b2b;
            pout_ready = 1'b1;
            step();
            start = 1'b0;
            pout_ready = 1'b0;
            checks++;
            if ({pout_valid, par_err, sin_ready, busy} !== {1'b0, 1'b0, b2b, b2b}) begin
                errors++;
                $display("FAIL rand_release%0d got %b exp %b", f,
                         {pout_valid, par_err, sin_ready, busy}, {2'b00, b2b, b2b});
            end
            in_shift = b2b;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop_b2b();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Sequencing controller for the serial-in/parallel-out shift-register datapath built from the team's D flip-flops. It accepts a start request, gates exactly WIDTH serial bits into a shift register using a per-bit valid/ready strobe, and presents the assembled word on a valid/ready parallel handshake. It sits between a serial bit source (switch/debounce logic or a serial link) and the parallel consumer (display or register file). It also provides frame-drop and optional parity-error reporting.

## Interface
- WIDTH, 4, number of data bits per frame; legal range 2..16
- clk  in  1  rising-edge clock, single clock domain
- r  in  1  reset; synchronous, active-high
- start  in  1  request to begin capturing one frame
- sin  in  1  serial data bit
- sin_valid  in  1  sin carries a bit this cycle
- sin_ready  out  1  controller accepts a bit this cycle
- pout  out  WIDTH  assembled parallel word
- pout_valid  out  1  pout holds a complete frame
- pout_ready  in  1  consumer accepts pout this cycle
- busy  out  1  high in every state except IDLE
- frame_drop  out  1  one-cycle pulse: start was ignored
- par_err  out  1  parity error for the frame on pout (see Configuration)

## Operation
- States: IDLE, SHIFT, PARITY (only with macro), HOLD.
- IDLE: sin_ready=0, pout_valid=0. On start=1, clear the shift register and bit counter, then go to SHIFT.
- SHIFT: sin_ready=1. On sin_valid=1, sr <= {sr[WIDTH-2:0], sin} and cnt <= cnt+1. The first accepted bit ends up in pout[WIDTH-1] (MSB-first).
  - When the WIDTH-th bit is accepted, go to PARITY if the macro is defined, otherwise to HOLD.
  - Cycles with sin_valid=0 stall; there is no timeout.
- PARITY: sin_ready=1. Accept one bit on sin_valid, record the parity result, then go to HOLD. No shift happens in this state.
- HOLD: pout_valid=1. pout and par_err are stable. sin_ready=0.
  - On pout_ready=1: go to IDLE.
  - On pout_ready=1 and start=1 in the same cycle: clear sr and cnt and go directly to SHIFT (back-to-back frames).
- Bit counter width is $clog2(WIDTH+1). Its terminal compare is cnt==WIDTH-1 together with an accepted bit. The counter never wraps.
- frame_drop pulses for one cycle when start=1 in SHIFT or PARITY, or in HOLD without pout_ready. The ignored start is not queued.
- pout is driven continuously from sr. Only pout_valid qualifies it.

## Timing
- Reset values: state=IDLE, sr=0 (pout=0), cnt=0, sin_ready=0, pout_valid=0, busy=0, frame_drop=0, par_err=0.
- Reset mid-frame or in HOLD discards the frame in the next cycle. No pout_valid is produced for it.
- sin_ready rises in the cycle after start is sampled in IDLE.
- pout_valid rises in the cycle after the last data bit is accepted (or the parity bit, with the macro).
- Minimum frame time from start to pout_valid: WIDTH+1 cycles without the macro, WIDTH+2 with it.
- pout_valid falls in the cycle after the handshake.
- With back-to-back start, sin_ready=1 in the cycle after the handshake.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Configuration
- SIPO_PARITY_CHECK_EN defined: the PARITY state exists and one even-parity bit follows the data bits.
  - par_err = ^{sr, parity_bit}.
  - par_err is valid while pout_valid=1 and clears to 0 on leaving HOLD.
- Not defined: no PARITY state, and SHIFT goes directly to HOLD. par_err is tied to 0.

## Test plan
- WIDTH=4, start, then bits 1,0,1,1 with sin_valid every cycle -> pout=4'b1011 and pout_valid=1 exactly 5 cycles after start; pout_ready=1 -> pout_valid=0 next cycle, busy=0.
- Same frame with sin_valid low on alternate cycles -> pout=4'b1011 and sin_ready stays 1 throughout SHIFT; hold pout_ready=0 for 10 cycles -> pout and pout_valid stay stable.
- In HOLD, assert start alone -> frame_drop=1 for one cycle, state unchanged. Assert start together with pout_ready -> SHIFT next cycle, next frame 0,1,1,0 -> pout=4'b0110.
- Assert r after 2 accepted bits -> next cycle all outputs at their reset values. A new frame 1,1,1,1 -> pout=4'b1111 with no corruption from the aborted frame.
- With SIPO_PARITY_CHECK_EN: data 1,0,1,1 with parity bit 1 -> par_err=0. With parity bit 0 -> par_err=1 while pout_valid is high, and par_err=0 after the handshake.
